// File: rtl/udp_tx_fifo_reader.sv
// UDP TX read-side packetizer: waits for a packet's worth of FIFO data,
// requests a send slot, then streams one fixed-length payload.
module udp_tx_fifo_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int PKT_WORDS  = 256,
  parameter int GAP_CYC    = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH:0]   fifo_rd_water_level,
  output logic                  fifo_rd_en,
  output logic                  tx_req,
  input  logic                  tx_ack,
  output logic [15:0]           tx_len,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic [15:0]           pkt_cnt,
  output logic                  busy
);

  localparam int PW = $clog2(PKT_WORDS + 1);
  localparam logic [ADDR_WIDTH:0] PKT_LVL = (ADDR_WIDTH + 1)'(PKT_WORDS);
  localparam logic [PW-1:0] POP_LD = PW'(PKT_WORDS);
  localparam logic [7:0] GAP_LD = 8'(GAP_CYC);
  localparam logic [15:0] TX_LEN = 16'(PKT_WORDS * (DATA_WIDTH / 8));

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SEND,
    S_GAP
  } state_e;

  state_e                state_q, state_d;
  logic                  lvl_ok_q, lvl_ok_d;
  logic [PW-1:0]         pop_left_q, pop_left_d;
  logic [7:0]            gap_q, gap_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  pop;
  logic                  eop;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q    <= S_IDLE;
      lvl_ok_q   <= 1'b0;
      pop_left_q <= '0;
      gap_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lvl_ok_q   <= lvl_ok_d;
      pop_left_q <= pop_left_d;
      gap_q      <= gap_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pop_left_d = pop_left_q;
    gap_d      = gap_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    lvl_ok_d   = fifo_rd_water_level >= PKT_LVL;

    // Pop only when the output slot is free or being drained this cycle.
    pop = (state_q == S_SEND) && (pop_left_q != '0)
        && !fifo_empty && (!valid_q || tx_ready);
    eop = valid_q && tx_ready && last_q;

    if (pop) begin
      data_d     = fifo_rd_data;
      valid_d    = 1'b1;
      pop_left_d = pop_left_q - PW'(1);
      last_d     = (pop_left_q == PW'(1));
    end else if (tx_ready) begin
      valid_d = 1'b0;
    end

    if (eop) begin
      last_d = 1'b0;
      cnt_d  = cnt_q + 16'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (lvl_ok_q) state_d = S_REQ;
      end
      S_REQ: begin
        if (tx_ack) begin
          state_d    = S_SEND;
          pop_left_d = POP_LD;
        end
      end
      S_SEND: begin
        if (eop) begin
          state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
          gap_d   = GAP_LD;
        end
      end
      S_GAP: begin
        if (gap_q <= 8'd1) state_d = S_IDLE;
        else gap_d = gap_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo_rd_en = pop;
  assign tx_req     = (state_q == S_REQ);
  assign tx_len     = TX_LEN;
  assign tx_data    = data_q;
  assign tx_valid   = valid_q;
  assign tx_last    = last_q;
  assign pkt_cnt    = cnt_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_udp_tx_fifo_reader.sv
// Bench for udp_tx_fifo_reader: FIFO model, scoreboard of expected beats,
// directed timing checks and a randomized streaming phase.
module tb_udp_tx_fifo_reader;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int PKW = 4;
  localparam int GAP = 2;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n = 1'b1;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_empty;
  logic [AW:0]   fifo_rd_water_level;
  logic          fifo_rd_en;
  logic          tx_req;
  logic          tx_ack = 1'b0;
  logic [15:0]   tx_len;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_last;
  logic          tx_ready = 1'b0;
  logic [15:0]   pkt_cnt;
  logic          busy;

  udp_tx_fifo_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .PKT_WORDS (PKW),
    .GAP_CYC   (GAP)
  ) dut (
    .rd_clk             (rd_clk),
    .rd_rst_n           (rd_rst_n),
    .fifo_rd_data       (fifo_rd_data),
    .fifo_empty         (fifo_empty),
    .fifo_rd_water_level(fifo_rd_water_level),
    .fifo_rd_en         (fifo_rd_en),
    .tx_req             (tx_req),
    .tx_ack             (tx_ack),
    .tx_len             (tx_len),
    .tx_data            (tx_data),
    .tx_valid           (tx_valid),
    .tx_last            (tx_last),
    .tx_ready           (tx_ready),
    .pkt_cnt            (pkt_cnt),
    .busy               (busy)
  );

  always #5 rd_clk = ~rd_clk;

  // Show-ahead FIFO model; it is reset together with the DUT.
  logic [DW-1:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;

  assign fifo_empty          = (wr_ptr == rd_ptr);
  assign fifo_rd_data        = mem[rd_ptr[3:0]];
  assign fifo_rd_water_level = 5'(wr_ptr - rd_ptr);

  always @(posedge rd_clk) begin
    if (!rd_rst_n) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int push_cnt = 0;
  int rdy_mode = 0;
  bit ack_auto = 1'b0;
  int ack_pend = 0;
  int ack_done = 0;
  int pat_i = 0;
  logic [6:0] pat = 7'b1101001;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge rd_clk);
    #3;
  endtask

  // Packets are fixed length, so the last flag follows the word index.
  task automatic push_word(input logic [DW-1:0] w);
    exp_t e;
    int n;
    n = 0;
    while ((wr_ptr - rd_ptr) >= 16 && n < 200) begin
      step();
      n++;
    end
    mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
    e.d = w;
    e.last = ((push_cnt % PKW) == PKW - 1);
    exp_q.push_back(e);
    push_cnt++;
  endtask

  task automatic wait_pkts(input string nm, input int n_exp);
    int n;
    n = 0;
    while (int'(pkt_cnt) != n_exp && n < 300) begin
      step();
      n++;
    end
    chk(nm, 32'(pkt_cnt), 32'(n_exp));
  endtask

  initial begin
    int m;
    int l_cyc;
    int r_cyc;
    int p0;
    int beats;
    exp_t e;

    #1 rd_rst_n = 1'b0;
    #1;
    chk("reset_ctrl", 32'({fifo_rd_en, tx_req, tx_valid, tx_last, busy}), 32'd0);
    chk("reset_data", tx_data, 32'd0);
    chk("reset_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("tx_len", 32'(tx_len), 32'(PKW * DW / 8));

    fork
      forever begin
        @(negedge rd_clk);
        if (rdy_mode == 0) tx_ready = 1'b1;
        else if (rdy_mode == 1) tx_ready = 1'($urandom_range(0, 1));
        else if (tx_valid) begin
          tx_ready = (pat_i < 7) ? pat[pat_i[2:0]] : 1'b1;
          pat_i++;
        end else tx_ready = 1'b1;
        tx_ack = ack_auto && tx_req;
        if (ack_pend != ack_done) begin
          tx_ack = 1'b1;
          ack_done = ack_pend;
        end
      end
      forever begin
        @(negedge rd_clk);
        #3;
        if (!rd_rst_n) exp_q.delete();
        else begin
          if (tx_valid && !tx_ready)
            chk("no_pop_on_stall", 32'(fifo_rd_en), 32'd0);
          if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) chk("unexpected_beat", tx_data, 32'hdead);
            else begin
              e = exp_q.pop_front();
              chk("beat_data", tx_data, e.d);
              chk("beat_last", 32'(tx_last), 32'(e.last));
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge rd_clk);
    rd_rst_n = 1'b1;
    step();

    // Threshold and request latency
    push_word(32'hA0);
    push_word(32'hA1);
    push_word(32'hA2);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("req_below_thr", 32'(tx_req), 32'd0);
    end
    p0 = pops;
    push_word(32'hA3);
    step();
    chk("req_n1", 32'(tx_req), 32'd0);
    step();
    chk("req_n2", 32'(tx_req), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("req_held", 32'(tx_req), 32'd1);
    end

    // Grant to data and streaming
    ack_pend++;
    m = 0;
    do begin
      step();
      m++;
    end while (!tx_ack && m < 10);
    chk("ack_seen", 32'(tx_ack), 32'd1);
    step();
    chk("grant_pop", 32'({fifo_rd_en, tx_valid}), 32'b10);
    step();
    for (int i = 0; i < PKW; i++) begin
      chk("stream_valid", 32'(tx_valid), 32'd1);
      chk("stream_last", 32'(tx_last), 32'(i == PKW - 1));
      step();
    end
    chk("gap_busy", 32'(busy), 32'd1);
    chk("pkt_cnt_1", 32'(pkt_cnt), 32'd1);
    step();
    step();
    chk("idle_after_gap", 32'(busy), 32'd0);
    chk("stream_pops", 32'(pops - p0), 32'(PKW));

    // Stray grant in IDLE
    ack_pend++;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stray_ack", 32'({busy, tx_req, fifo_rd_en}), 32'd0);
    end

    // Backpressure
    rdy_mode = 2;
    pat_i = 0;
    ack_auto = 1'b1;
    p0 = pops;
    for (int i = 0; i < PKW; i++) push_word(32'hB0 + 32'(i));
    wait_pkts("bp_pkt_cnt", 2);
    chk("bp_pops", 32'(pops - p0), 32'(PKW));
    repeat (4) step();
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back packets
    rdy_mode = 0;
    for (int i = 0; i < 2 * PKW; i++) push_word(32'hC0 + 32'(i));
    l_cyc = -1;
    r_cyc = -1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (tx_valid && tx_ready && tx_last && l_cyc < 0) l_cyc = i;
      if (l_cyc >= 0 && tx_req && r_cyc < 0) r_cyc = i;
      if (int'(pkt_cnt) == 4 && !busy) break;
    end
    chk("b2b_spacing", 32'(r_cyc - l_cyc), 32'(GAP + 2));
    chk("b2b_pkt_cnt", 32'(pkt_cnt), 32'(push_cnt / PKW));

    // Reset mid-SEND after two beats
    for (int i = 0; i < PKW; i++) push_word(32'hD0 + 32'(i));
    beats = 0;
    m = 0;
    while (beats < 2 && m < 100) begin
      step();
      m++;
      if (tx_valid && tx_ready) beats++;
    end
    chk("rst_beats", 32'(beats), 32'd2);
    step();
    #1 rd_rst_n = 1'b0;
    push_cnt = 0;
    #1;
    chk("rst_mid_ctrl", 32'({fifo_rd_en, tx_req, tx_valid, tx_last, busy}), 32'd0);
    chk("rst_mid_data", tx_data, 32'd0);
    chk("rst_mid_cnt", 32'(pkt_cnt), 32'd0);
    repeat (2) @(negedge rd_clk);
    rd_rst_n = 1'b1;
    step();
    chk("rst_idle", 32'(busy), 32'd0);
    p0 = pops;
    for (int i = 0; i < PKW; i++) push_word(32'hE0 + 32'(i));
    wait_pkts("post_rst_pkt", 1);
    chk("post_rst_pops", 32'(pops - p0), 32'(PKW));

    // Randomized streaming
    rdy_mode = 1;
    for (int i = 0; i < 6 * PKW; i++) begin
      m = 0;
      while ((wr_ptr - rd_ptr) > 12 && m < 200) begin
        step();
        m++;
      end
      push_word(32'($urandom()));
      repeat ($urandom_range(0, 2)) step();
    end
    m = 0;
    while (!(exp_q.size() == 0 && !busy && fifo_empty) && m < 2000) begin
      step();
      m++;
    end
    step();
    chk("rand_pkt_cnt", 32'(pkt_cnt), 32'(push_cnt / PKW));
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_tx_fifo_reader.md
# udp_tx_fifo_reader

Read-side packetizer for the UDP transmit path. It drains the show-ahead distributed FIFO that buffers captured video words, waits until a full packet's worth of data is stored, and requests a send slot from the UDP stack. After the grant it streams exactly one fixed-length payload with a valid/ready/last handshake. It sits between the FIFO read port and the UDP TX core, in the read clock domain.

## Interface
Parameters:
- DATA_WIDTH, 32, payload word width; must be a multiple of 8, range 8–256.
- ADDR_WIDTH, 10, FIFO address width; must match the FIFO instance.
- PKT_WORDS, 256, words per packet; range 1 to 2^ADDR_WIDTH.
- GAP_CYC, 4, idle cycles forced between packets; range 0–255.

Ports:
- rd_clk  in  1  single clock for the whole block.
- rd_rst_n  in  1  asynchronous active-low reset.
- fifo_rd_data  in  DATA_WIDTH  FIFO head word; valid whenever fifo_empty=0 (show-ahead).
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_water_level  in  ADDR_WIDTH+1  number of words stored in the FIFO.
- fifo_rd_en  out  1  pops the head word.
- tx_req  out  1  packet-ready request to the UDP core.
- tx_ack  in  1  one-cycle grant.
- tx_len  out  16  payload length in bytes.
- tx_data  out  DATA_WIDTH  payload word.
- tx_valid  out  1  tx_data is valid.
- tx_last  out  1  marks the final word of the packet.
- tx_ready  in  1  sink accepts the word.
- pkt_cnt  out  16  count of packets sent.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, REQ, SEND, GAP.
- IDLE → REQ when the registered flag (fifo_rd_water_level >= PKT_WORDS) is 1. The level comparison uses ADDR_WIDTH+1 bits.
- REQ: tx_req is held at 1 until tx_ack is sampled high, then the FSM moves to SEND. tx_ack is ignored in every other state.
- SEND:
  - pop_left counter is loaded with PKT_WORDS on entry. Its width is clog2(PKT_WORDS+1).
  - fifo_rd_en = SEND & (pop_left≠0) & ~fifo_empty & (~tx_valid | tx_ready).
  - On fifo_rd_en: the output register loads fifo_rd_data, tx_valid is set to 1, pop_left is decremented, and tx_last is set to 1 if pop_left was 1.
  - If tx_ready is high with no pop, tx_valid clears.
  - The block never pops more than PKT_WORDS words per packet.
- End of packet: when tx_valid & tx_ready & tx_last:
  - pkt_cnt increments (wraps at 2^16), tx_last clears.
  - FSM goes to GAP, or to IDLE if GAP_CYC=0.
- GAP: a counter runs for GAP_CYC cycles, then the FSM returns to IDLE.
- tx_len is the constant PKT_WORDS*DATA_WIDTH/8, truncated to 16 bits.
- FIFO going empty inside SEND is tolerated: the block stalls with no pop and no bubble beyond the stall. This case is unreachable while the FIFO has a single reader.
- Reset (asynchronous, any state): the FSM returns to IDLE and all counters and outputs clear. A packet in flight is abandoned. The FIFO is not reset by this block; the system resets the FIFO and this block together.

## Timing
- Reset values: fifo_rd_en=0, tx_req=0, tx_valid=0, tx_last=0, tx_data=0, pkt_cnt=0, busy=0. tx_len is constant.
- Request latency: level≥PKT_WORDS at cycle N → flag set at N+1 → tx_req=1 at N+2.
- Grant to data: tx_ack at cycle M → first fifo_rd_en at M+1 → tx_valid=1 at M+2.
- With tx_ready held high: one word per cycle; the packet occupies PKT_WORDS consecutive cycles.
- tx_data, tx_valid and tx_last stay stable while tx_valid=1 and tx_ready=0.
- Packet-to-packet spacing, last beat to next tx_req: GAP_CYC+1 cycles minimum, plus the level check.
- tx_valid, tx_data and tx_last are registered; fifo_rd_en is combinational from state and inputs.

## Test plan
All scenarios use PKT_WORDS=4, GAP_CYC=2, DATA_WIDTH=32, ADDR_WIDTH=4.
- Reset: assert rd_rst_n=0 mid-cycle → every output goes to its reset value immediately. tx_len=16.
- Threshold: level=3 held for 20 cycles → tx_req stays 0. Level=4 at cycle N → tx_req=1 at N+2 and stays high until tx_ack.
- Streaming: FIFO holds 0xA0..0xA3, tx_ready=1, tx_ack pulsed → exactly 4 pops. tx_data sequence is A0, A1, A2, A3 on consecutive cycles, tx_last only with A3, then pkt_cnt=1 and busy=0 after 3 cycles.
- Backpressure: tx_ready pattern 1,0,0,1,0,1,1 → no word lost or duplicated. tx_data stays stable while stalled. fifo_rd_en is never high while tx_valid=1 and tx_ready=0.
- Back-to-back: level=8 and tx_ack answered immediately → two packets separated by at least 3 idle cycles. pkt_cnt=2. A stray tx_ack in IDLE causes no effect.
- Reset mid-SEND after 2 beats → outputs clear, FSM is in IDLE. A new 4-word packet after reset releases streams normally.
